// File: rtl/utopia2_pkg.sv
// Shared types and constants for the UTOPIA Level 2 multi-PHY ATM cell receiver.
package utopia2_pkg;

    typedef enum logic [1:0] {POLL, SELECT, XFER, HOLD} rx_state_e;

    localparam logic [4:0] NULL_ADDR  = 5'd31;
    localparam int         CELL_BYTES = 53;
    localparam logic [7:0] HEC_COSET  = 8'h55;

    // Raw CRC-8 (x^8+x^2+x+1) over the four header bytes, byte 0 first; coset applied by caller.
    function automatic logic [7:0] hec_crc8(input logic [31:0] hdr);
        logic [7:0] crc;
        crc = 8'h00;
        for (int b = 0; b < 4; b++) begin
            crc = crc ^ hdr[31-8*b -: 8];
            for (int k = 0; k < 8; k++)
                crc = crc[7] ? ({crc[6:0], 1'b0} ^ 8'h07) : {crc[6:0], 1'b0};
        end
        return crc;
    endfunction

endpackage

// File: rtl/utopia2_hec_calc.sv
// Combinational HEC generator (CRC-8 plus coset); only built when UTOPIA2_HEC_CHECK_EN is defined.
`ifdef UTOPIA2_HEC_CHECK_EN
module utopia2_hec_calc
    import utopia2_pkg::*;
(
    input  logic [31:0] hdr,
    output logic [7:0]  hec
);
    assign hec = hec_crc8(hdr) ^ HEC_COSET;
endmodule
`endif

// File: rtl/utopia2_atm_rx.sv
// UTOPIA Level 2 multi-PHY ATM cell receiver: round-robin poll, select, one-cell capture, valid/ready hand-off.
// Optional header check enabled by UTOPIA2_HEC_CHECK_EN (adds hec_err_cnt port).
module utopia2_atm_rx
    import utopia2_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_PHY   = 4,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk_in,
    input  logic                 reset,
    output logic                 clk_out,
    output logic [ADDR_W-1:0]    rx_addr,
    output logic                 rx_enb_n,
    input  logic                 rx_clav,
    input  logic                 rx_soc,
    input  logic [BUS_WIDTH-1:0] rx_data,
    output logic [423:0]         cell_o,
    output logic [ADDR_W-1:0]    cell_phy,
    output logic                 cell_valid,
    input  logic                 cell_ready,
    output logic [15:0]          soc_err_cnt
`ifdef UTOPIA2_HEC_CHECK_EN
    ,
    output logic [15:0]          hec_err_cnt
`endif
);

    localparam int                CELL_WORDS = (BUS_WIDTH == 16) ? 27 : CELL_BYTES;
    localparam logic [5:0]        LAST_WORD  = 6'(CELL_WORDS - 1);
    localparam logic [ADDR_W-1:0] NULL_A     = ADDR_W'(NULL_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PHY   = ADDR_W'(NUM_PHY - 1);

    function automatic logic [ADDR_W-1:0] next_phy(input logic [ADDR_W-1:0] p);
        return (p >= LAST_PHY) ? '0 : p + ADDR_W'(1);
    endfunction

    rx_state_e         state, state_nx;
    logic [ADDR_W-1:0] poll_ptr, poll_ptr_nx;
    logic [ADDR_W-1:0] sel_phy, sel_nx;
    logic [ADDR_W-1:0] rx_addr_nx, addr_d;
    logic              enb_nx, en_low_d;
    logic [5:0]        word_idx;
    logic              started;
    logic              data_vld, soc_beat, word_beat, last_beat, udf_word, hec_ok;
    logic [423:0]      cell_shift;

    assign clk_out = clk_in;

    // PHY drives data one cycle after it sees enable low.
    assign data_vld  = (state == XFER) && en_low_d;
    assign soc_beat  = data_vld && rx_soc;
    assign word_beat = data_vld && !rx_soc && rx_clav && started;
    assign last_beat = word_beat && (word_idx == LAST_WORD);

    // In 16-bit mode word 2 carries HEC in the high byte and the UDF in the low byte.
    assign udf_word   = (BUS_WIDTH == 16) && (word_idx == 6'd2);
    assign cell_shift = udf_word ? {cell_o[415:0], rx_data[BUS_WIDTH-1 -: 8]}
                                 : {cell_o[423-BUS_WIDTH:0], rx_data};

`ifdef UTOPIA2_HEC_CHECK_EN
    logic [7:0] hec_calc;
    utopia2_hec_calc u_hec (.hdr(cell_shift[423:392]), .hec(hec_calc));
    assign hec_ok = (hec_calc == cell_shift[391:384]);
`else
    assign hec_ok = 1'b1;
`endif

    always_comb begin
        state_nx    = state;
        poll_ptr_nx = poll_ptr;
        sel_nx      = sel_phy;
        rx_addr_nx  = NULL_A;
        enb_nx      = 1'b1;
        unique case (state)
            POLL: begin
                // clav answers the address driven one cycle earlier (addr_d)
                if (rx_clav && addr_d != NULL_A) begin
                    state_nx    = SELECT;
                    sel_nx      = addr_d;
                    rx_addr_nx  = addr_d;
                    poll_ptr_nx = next_phy(addr_d);
                end else begin
                    rx_addr_nx  = poll_ptr;
                    poll_ptr_nx = next_phy(poll_ptr);
                end
            end
            SELECT: begin
                state_nx = XFER;
                enb_nx   = 1'b0;
            end
            XFER: begin
                enb_nx = 1'b0;
                if (last_beat) begin
                    enb_nx = 1'b1;
                    if (hec_ok) begin
                        state_nx = HOLD;
                    end else begin
                        state_nx    = POLL;
                        rx_addr_nx  = poll_ptr;
                        poll_ptr_nx = next_phy(poll_ptr);
                    end
                end
            end
            HOLD: begin
                if (cell_ready) begin
                    state_nx    = POLL;
                    rx_addr_nx  = poll_ptr;
                    poll_ptr_nx = next_phy(poll_ptr);
                end
            end
            default: state_nx = POLL;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= POLL;
            poll_ptr    <= '0;
            sel_phy     <= '0;
            rx_addr     <= NULL_A;
            rx_enb_n    <= 1'b1;
            addr_d      <= NULL_A;
            en_low_d    <= 1'b0;
            word_idx    <= '0;
            started     <= 1'b0;
            cell_o      <= '0;
            cell_phy    <= '0;
            cell_valid  <= 1'b0;
            soc_err_cnt <= '0;
        end else begin
            state    <= state_nx;
            poll_ptr <= poll_ptr_nx;
            sel_phy  <= sel_nx;
            rx_addr  <= rx_addr_nx;
            rx_enb_n <= enb_nx;
            addr_d   <= rx_addr;
            en_low_d <= !rx_enb_n;

            if (state == SELECT) begin
                started  <= 1'b0;
                word_idx <= '0;
            end else if (soc_beat) begin
                cell_o   <= cell_shift;
                word_idx <= 6'd1;
                started  <= 1'b1;
                if (started && soc_err_cnt != 16'hFFFF)
                    soc_err_cnt <= soc_err_cnt + 16'd1;
            end else if (word_beat) begin
                cell_o   <= cell_shift;
                word_idx <= word_idx + 6'd1;
            end

            if (last_beat && hec_ok) begin
                cell_valid <= 1'b1;
                cell_phy   <= sel_phy;
            end else if (cell_valid && cell_ready) begin
                cell_valid <= 1'b0;
            end
        end
    end

`ifdef UTOPIA2_HEC_CHECK_EN
    always_ff @(posedge clk_in) begin
        if (reset)
            hec_err_cnt <= '0;
        else if (last_beat && !hec_ok && hec_err_cnt != 16'hFFFF)
            hec_err_cnt <= hec_err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_utopia2_atm_rx.sv
// Directed bench: 8-bit/4-PHY instance for polling, hand-off, pause, resync and reset; 16-bit/1-PHY instance for UDF drop.
module tb_utopia2_atm_rx;

    logic         clk_in = 1'b0;
    logic         reset;
    int           checks = 0;
    int           errors = 0;

    // 8-bit, 4-PHY instance
    logic         clk_out, rx_enb_n, rx_clav, rx_soc, cell_valid, cell_ready;
    logic [4:0]   rx_addr, cell_phy;
    logic [7:0]   rx_data;
    logic [423:0] cell_o;
    logic [15:0]  soc_err_cnt;

    // 16-bit, 1-PHY instance
    logic         w_clk_out, w_enb_n, w_clav, w_soc, w_valid, w_ready;
    logic [4:0]   w_addr, w_phy;
    logic [15:0]  w_data;
    logic [423:0] w_cell;
    logic [15:0]  w_soc_err;

`ifdef UTOPIA2_HEC_CHECK_EN
    logic [15:0]  hec_err_cnt, w_hec_err;
`endif

    logic [4:0]   last_addr;
    logic [3:0]   avail;

    always #5 clk_in = ~clk_in;

    utopia2_atm_rx #(.BUS_WIDTH(8), .NUM_PHY(4), .ADDR_W(5)) dut8 (
        .clk_in(clk_in), .reset(reset), .clk_out(clk_out),
        .rx_addr(rx_addr), .rx_enb_n(rx_enb_n), .rx_clav(rx_clav), .rx_soc(rx_soc), .rx_data(rx_data),
        .cell_o(cell_o), .cell_phy(cell_phy), .cell_valid(cell_valid), .cell_ready(cell_ready),
        .soc_err_cnt(soc_err_cnt)
`ifdef UTOPIA2_HEC_CHECK_EN
        , .hec_err_cnt(hec_err_cnt)
`endif
    );

    utopia2_atm_rx #(.BUS_WIDTH(16), .NUM_PHY(1), .ADDR_W(5)) dut16 (
        .clk_in(clk_in), .reset(reset), .clk_out(w_clk_out),
        .rx_addr(w_addr), .rx_enb_n(w_enb_n), .rx_clav(w_clav), .rx_soc(w_soc), .rx_data(w_data),
        .cell_o(w_cell), .cell_phy(w_phy), .cell_valid(w_valid), .cell_ready(w_ready),
        .soc_err_cnt(w_soc_err)
`ifdef UTOPIA2_HEC_CHECK_EN
        , .hec_err_cnt(w_hec_err)
`endif
    );

    task automatic chk(input string tag, input logic [423:0] obs, input logic [423:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-8 with coset, header MSB first.
    function automatic logic [7:0] hec_of(input logic [31:0] h);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ h[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c ^ 8'h55;
    endfunction

    function automatic logic [7:0] cbyte(input int i, input int seed);
        logic [31:0] hdr;
        hdr = 32'h12345678;
        if (i < 4)  return hdr[31-8*i -: 8];
        if (i == 4) return hec_of(hdr);
        return 8'(i - 5 + seed);
    endfunction

    function automatic logic [423:0] exp_cell(input int seed);
        logic [423:0] c;
        for (int i = 0; i < 53; i++) c[423-8*i -: 8] = cbyte(i, seed);
        return c;
    endfunction

    // One cycle of the PHY-side poll model: clav answers the address seen a cycle ago.
    task automatic poll_cycle();
        @(negedge clk_in);
        rx_clav   = (last_addr < 5'd4) ? avail[last_addr[1:0]] : 1'b0;
        last_addr = rx_addr;
    endtask

    task automatic xfer_cell(input int phy, input int pre, input int pause_at, input int seed,
                             input logic [7:0] hec_x);
        logic to;
        to        = 1'b1;
        last_addr = 5'd31;
        avail     = '0;
        avail[phy] = 1'b1;
        for (int n = 0; n < 64; n++) begin
            poll_cycle();
            if (!rx_enb_n) begin
                to = 1'b0;
                break;
            end
        end
        avail = '0;
        chk("select_timeout", {423'd0, to}, 424'd0);
        if (to) return;
        rx_clav = 1'b1;
        rx_soc  = 1'b0;
        for (int j = 0; j < pre; j++) begin
            @(negedge clk_in);
            rx_soc  = (j == 0);
            rx_data = 8'(8'hC0 + j);
        end
        for (int i = 0; i < 53; i++) begin
            if (i == pause_at) begin
                @(negedge clk_in);
                rx_clav = 1'b0;
                rx_soc  = 1'b0;
                rx_data = 8'hEE;
            end
            @(negedge clk_in);
            rx_clav = 1'b1;
            rx_soc  = (i == 0);
            rx_data = cbyte(i, seed) ^ ((i == 4) ? hec_x : 8'h00);
        end
        @(negedge clk_in);
        rx_soc  = 1'b0;
        rx_clav = 1'b0;
    endtask

    task automatic accept();
        cell_ready = 1'b1;
        @(negedge clk_in);
        cell_ready = 1'b0;
        chk("valid_cleared", {423'd0, cell_valid}, 424'd0);
    endtask

    initial begin
        logic [423:0] held;
        logic [15:0]  wd;
        logic         to;
        reset = 1'b1; rx_clav = 0; rx_soc = 0; rx_data = 0; cell_ready = 0;
        w_clav = 0; w_soc = 0; w_data = 0; w_ready = 0;
        avail = '0; last_addr = 5'd31;
        repeat (3) @(negedge clk_in);

        chk("rst_addr",    rx_addr,     31);
        chk("rst_enb",     rx_enb_n,    1);
        chk("rst_valid",   cell_valid,  0);
        chk("rst_phy",     cell_phy,    0);
        chk("rst_cell",    cell_o,      0);
        chk("rst_soc_err", soc_err_cnt, 0);
        chk("clk_out",     clk_out,     clk_in);
`ifdef UTOPIA2_HEC_CHECK_EN
        chk("rst_hec_err", hec_err_cnt, 0);
`endif
        reset = 1'b0;

        // idle polling: 0,1,2,3,0,1 on the 4-PHY port, always 0 on the 1-PHY port
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            chk("poll_addr",  rx_addr, k % 4);
            chk("poll_enb",   rx_enb_n, 1);
            chk("poll_valid", cell_valid, 0);
            chk("w_poll_addr", w_addr, 0);
        end

        // PHY 2 cell, payload = index
        xfer_cell(2, 0, -1, 0, 8'h00);
        chk("c1_valid", cell_valid, 1);
        chk("c1_phy",   cell_phy, 2);
        chk("c1_cell",  cell_o, exp_cell(0));
        accept();
        chk("c1_next_poll", rx_addr, 3);

        // PHY 0 cell with a one-cycle clav pause before byte 30
        xfer_cell(0, 0, 30, 1, 8'h00);
        chk("c2_valid", cell_valid, 1);
        chk("c2_phy",   cell_phy, 0);
        chk("c2_cell",  cell_o, exp_cell(1));
        chk("c2_soc_err", soc_err_cnt, 0);

        // hold off the core for 10 cycles while another PHY has a cell
        held    = cell_o;
        rx_clav = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            chk("hold_valid", cell_valid, 1);
            chk("hold_cell",  cell_o, held);
            chk("hold_addr",  rx_addr, 31);
            chk("hold_enb",   rx_enb_n, 1);
        end
        rx_clav = 1'b0;
        accept();
        xfer_cell(1, 0, -1, 2, 8'h00);
        chk("c3_valid", cell_valid, 1);
        chk("c3_phy",   cell_phy, 1);
        chk("c3_cell",  cell_o, exp_cell(2));
        accept();

        // resync: second soc arrives at word 20
        xfer_cell(3, 20, -1, 5, 8'h00);
        chk("rs_valid",   cell_valid, 1);
        chk("rs_phy",     cell_phy, 3);
        chk("rs_cell",    cell_o, exp_cell(5));
        chk("rs_soc_err", soc_err_cnt, 1);
        accept();

`ifdef UTOPIA2_HEC_CHECK_EN
        xfer_cell(0, 0, -1, 3, 8'h01);
        chk("hec_drop_valid", cell_valid, 0);
        chk("hec_err_cnt",    hec_err_cnt, 1);
        xfer_cell(2, 0, -1, 4, 8'h00);
        chk("hec_good_valid", cell_valid, 1);
        chk("hec_good_cell",  cell_o, exp_cell(4));
        chk("hec_err_hold",   hec_err_cnt, 1);
        accept();
`endif

        // 16-bit port: 27 words, UDF 0xAA in word 2 low byte
        w_clav = 1'b1;
        to = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_in);
            if (!w_enb_n) begin
                to = 1'b0;
                break;
            end
        end
        chk("w_select_timeout", {423'd0, to}, 424'd0);
        for (int k = 0; k < 27; k++) begin
            @(negedge clk_in);
            if (k < 2)       wd = {cbyte(2*k, 9), cbyte(2*k+1, 9)};
            else if (k == 2) wd = {cbyte(4, 9), 8'hAA};
            else             wd = {cbyte(2*k-1, 9), cbyte(2*k, 9)};
            w_soc  = (k == 0);
            w_data = wd;
        end
        @(negedge clk_in);
        w_soc = 1'b0; w_clav = 1'b0;
        chk("w_valid", w_valid, 1);
        chk("w_phy",   w_phy, 0);
        chk("w_cell",  w_cell, exp_cell(9));
        w_ready = 1'b1;
        @(negedge clk_in);
        w_ready = 1'b0;
        chk("w_valid_cleared", w_valid, 0);

        // reset in the middle of a cell
        avail = '0; avail[1] = 1'b1; last_addr = 5'd31; to = 1'b1;
        for (int n = 0; n < 64; n++) begin
            poll_cycle();
            if (!rx_enb_n) begin
                to = 1'b0;
                break;
            end
        end
        avail = '0;
        chk("mr_select_timeout", {423'd0, to}, 424'd0);
        rx_clav = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            rx_soc  = (i == 0);
            rx_data = 8'(i);
        end
        @(negedge clk_in);
        reset = 1'b1; rx_soc = 0; rx_clav = 0;
        @(negedge clk_in);
        chk("mr_addr",    rx_addr, 31);
        chk("mr_enb",     rx_enb_n, 1);
        chk("mr_valid",   cell_valid, 0);
        chk("mr_soc_err", soc_err_cnt, 0);
        chk("mr_cell",    cell_o, 0);
        reset = 1'b0;
        @(negedge clk_in);
        chk("mr_poll0", rx_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/utopia2_atm_rx.md
Name: utopia2_atm_rx

Overview:
- Parametrised UTOPIA Level 2 multi-PHY ATM cell receiver; ATM-layer side of the UNI port, feeding the forwarding core.
- Round-robin polls up to NUM_PHY PHY addresses for cell-available, selects one PHY and receives one 53-byte cell over an 8- or 16-bit bus.
- Buffers the cell in a single-cell holding register and hands it to the core with a valid/ready handshake, tagged with the source PHY.

Parameters:
- BUS_WIDTH, 8: UTOPIA data width, 8 or 16. In 16-bit mode a cell is 27 words; byte 5 is the UDF and is discarded.
- NUM_PHY, 4: number of polled PHYs, 1..31. Address 31 is the null address.
- ADDR_W, 5: PHY address width.

Ports:
- clk_in  in  1  receive clock; also drives clk_out.
- reset  in  1  synchronous, active-high.
- clk_out  out  1  equals clk_in.
- rx_addr  out  ADDR_W  poll/select address.
- rx_enb_n  out  1  receive enable, active low.
- rx_clav  in  1  cell-available from the addressed PHY.
- rx_soc  in  1  start of cell.
- rx_data  in  BUS_WIDTH  cell data.
- cell_o  out  424  received cell, byte 0 (GFC/VPI) in bits [423:416], payload byte 47 in [7:0].
- cell_phy  out  ADDR_W  source PHY of cell_o.
- cell_valid  out  1  cell_o holds a complete cell.
- cell_ready  in  1  core accepts the cell.
- soc_err_cnt  out  16  count of misaligned starts of cell; saturates at 0xFFFF.

Behaviour:
- Single clock, clk_in; reset is synchronous and active-high.
- Reset values: rx_addr=31, rx_enb_n=1, cell_valid=0, cell_phy=0, cell_o=0, soc_err_cnt=0, poll pointer=0, state POLL.
- State POLL:
  - Each cycle, drive rx_addr = poll_ptr. poll_ptr advances modulo NUM_PHY.
  - rx_clav sampled in cycle t refers to the address driven in cycle t-1.
  - On a sampled clav=1, record that PHY as sel_phy and go to SELECT.
  - With NUM_PHY=1, poll address 0 continuously.
- State SELECT (1 cycle):
  - Drive rx_addr=sel_phy, rx_enb_n=1, then go to XFER.
  - Next poll resumes at sel_phy+1 (mod NUM_PHY) for fairness.
- State XFER:
  - Drive rx_addr=31 and rx_enb_n=0.
  - Data is valid the cycle after rx_enb_n goes low.
  - Words before the first rx_soc=1 are ignored.
  - rx_soc=1 captures word 0. word_idx counts 0..CELL_WORDS-1, where CELL_WORDS is 53 for 8-bit and 27 for 16-bit; the 16-bit UDF byte is dropped.
  - A cycle with rx_clav=0 after word 0 is a pause: no capture, word_idx holds.
  - rx_soc=1 at word_idx≠0 is a resync: restart capture at word 0 and increment soc_err_cnt.
  - Capturing the last word: rx_enb_n=1, cell_valid=1 on the next edge, cell_phy=sel_phy, go to HOLD.
- State HOLD:
  - cell_o and cell_phy are stable while cell_valid=1.
  - Transfer occurs on the edge where cell_valid && cell_ready; cell_valid clears and the state returns to POLL.
  - No polling while in HOLD; rx_addr=31.
- Latency: last data word to cell_valid is 1 cycle. cell_ready is accepted in the same cycle, so back-to-back cells are possible.
- Reset asserted mid-cell discards the partial cell; the interface returns to reset values next edge.

Optional Feature:
- Macro: UTOPIA2_HEC_CHECK_EN.
- Defined:
  - Compute CRC-8 (x^8+x^2+x+1) over header bytes 0..3, XOR with 0x55, and compare against byte 4.
  - On mismatch, the cell is dropped: no cell_valid, return to POLL.
  - Output hec_err_cnt [15:0] increments per drop and saturates.
- Undefined: no check, no hec_err_cnt port, every cell is delivered.

Decomposition:
- Package utopia2_pkg holds:
  - rx_state_e enum {POLL, SELECT, XFER, HOLD}
  - constants NULL_ADDR=31, CELL_BYTES=53, HEC_COSET=8'h55
  - function hec_crc8().
- Sub-module utopia2_hec_calc: combinational/byte-serial CRC-8, instantiated only under UTOPIA2_HEC_CHECK_EN.

Test Plan:
- Reset then NUM_PHY=4 with all clav=0 -> rx_addr cycles 0,1,2,3,0...; rx_enb_n stays 1; cell_valid=0.
- PHY 2 clav=1 and sends cell, header 0x12 0x34 0x56 0x78 plus HEC, payload bytes 0..47 = index -> cell_valid with cell_phy=2 and cell_o matching; next poll address is 3.
- Hold cell_ready=0 for 10 cycles while PHY 1 asserts clav -> cell_o stable, no SELECT; after ready=1, PHY 1 is served.
- Second rx_soc at byte 20 -> soc_err_cnt=1; the cell restarted from the new soc is delivered intact.
- BUS_WIDTH=16, 27 words with UDF=0xAA -> cell_o excludes 0xAA; payload is correct.
- With UTOPIA2_HEC_CHECK_EN, corrupt the HEC byte -> no cell_valid, hec_err_cnt=1. A following good cell is delivered.
